// File: rtl/alu_stack_seq.sv
// rtl/alu_stack_seq.sv - operand-stack sequencer driving a registered external ALU
// Stack is a shift register: entry 0 is TOS, entry 1 is NOS.
module alu_stack_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [1:0]                     i_cmd,
  input  logic [3:0]                     i_op,
  input  logic [WIDTH-1:0]               i_data,
  output logic [WIDTH-1:0]               o_tos,
  output logic [WIDTH-1:0]               o_nos,
  output logic [$clog2(DEPTH+1)-1:0]     o_depth,
  output logic                           o_err,
  output logic [3:0]                     o_alu_op,
  output logic [WIDTH-1:0]               o_alu_arg0,
  output logic [WIDTH-1:0]               o_alu_arg1,
  input  logic [WIDTH-1:0]               i_alu_data
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);
  // ADD=0 SUB=1 MUL=2 AND=3 OR=4 XOR=5 are binary; ROL=6 and every higher code are unary
  localparam logic [3:0] OP_LAST_BINARY = 4'd5;

  localparam logic [1:0] CMD_PUSH = 2'd0;
  localparam logic [1:0] CMD_POP  = 2'd1;
  localparam logic [1:0] CMD_DUP  = 2'd2;
  localparam logic [1:0] CMD_ALU  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_depth;
  logic             r_err;
  logic             r_unary;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_arg0;
  logic [WIDTH-1:0] r_alu_arg1;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic w_accept;
  logic w_binary;

  assign o_ready    = (r_state == S_IDLE) && !i_rst;
  assign w_accept   = i_valid && o_ready;
  assign w_binary   = (i_op <= OP_LAST_BINARY);
  assign o_tos      = (r_depth != '0) ? r_stack[0] : '0;
  assign o_nos      = (r_depth >= TWO) ? r_stack[1] : '0;
  assign o_depth    = r_depth;
  assign o_err      = r_err;
  assign o_alu_op   = r_alu_op;
  assign o_alu_arg0 = r_alu_arg0;
  assign o_alu_arg1 = r_alu_arg1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_unary    <= 1'b0;
      r_alu_op   <= '0;
      r_alu_arg0 <= '0;
      r_alu_arg1 <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (i_cmd)
              CMD_PUSH: begin
                if (r_depth < FULL) begin
                  r_stack[0] <= i_data;
                  for (int k = 1; k < DEPTH; k++) r_stack[k] <= r_stack[k-1];
                  r_depth <= r_depth + ONE;
                end else begin
                  r_err <= 1'b1;
                end
              end
              CMD_POP: begin
                if (r_depth != '0) begin
                  for (int k = 0; k < DEPTH - 1; k++) r_stack[k] <= r_stack[k+1];
                  r_depth <= r_depth - ONE;
                end else begin
                  r_err <= 1'b1;
                end
              end
              CMD_DUP: begin
                if ((r_depth != '0) && (r_depth < FULL)) begin
                  for (int k = 1; k < DEPTH; k++) r_stack[k] <= r_stack[k-1];
                  r_depth <= r_depth + ONE;
                end else begin
                  r_err <= 1'b1;
                end
              end
              CMD_ALU: begin
                if (w_binary ? (r_depth >= TWO) : (r_depth != '0)) begin
                  r_alu_op   <= i_op;
                  r_alu_arg0 <= w_binary ? r_stack[1] : r_stack[0];
                  r_alu_arg1 <= w_binary ? r_stack[0] : '0;
                  r_unary    <= !w_binary;
                  r_state    <= S_ISSUE;
                end else begin
                  r_err <= 1'b1;
                end
              end
              default: r_err <= 1'b0;
            endcase
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          // Binary result replaces both operands: shift the rest up by one under the new TOS
          r_stack[0] <= i_alu_data;
          if (!r_unary) begin
            for (int k = 1; k < DEPTH - 1; k++) r_stack[k] <= r_stack[k+1];
            r_depth <= r_depth - ONE;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stack_seq.sv
// tb/tb_alu_stack_seq.sv - randomized self-checking bench for alu_stack_seq
// Reference model is a queue-based stack (back = TOS) plus a behavioural registered ALU.
module tb_alu_stack_seq;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [1:0]       i_cmd = 2'd0;
  logic [3:0]       i_op = 4'd0;
  logic [WIDTH-1:0] i_data = '0;
  logic [WIDTH-1:0] o_tos, o_nos;
  logic [3:0]       o_depth;
  logic             o_err;
  logic [3:0]       o_alu_op;
  logic [WIDTH-1:0] o_alu_arg0, o_alu_arg1;
  logic [WIDTH-1:0] i_alu_data = '0;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] m_stk[$];

  alu_stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_cmd(i_cmd), .i_op(i_op), .i_data(i_data),
    .o_tos(o_tos), .o_nos(o_nos), .o_depth(o_depth), .o_err(o_err),
    .o_alu_op(o_alu_op), .o_alu_arg0(o_alu_arg0), .o_alu_arg1(o_alu_arg1),
    .i_alu_data(i_alu_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return WIDTH'((a * b) % 256);
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return {a[WIDTH-2:0], a[WIDTH-1]};
      default: return ~a;
    endcase
  endfunction

  always @(posedge i_clk) i_alu_data <= alu_f(o_alu_op, o_alu_arg0, o_alu_arg1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int n = m_stk.size();
    check({tag, "_depth"}, 32'(o_depth), 32'(n));
    check({tag, "_tos"}, 32'(o_tos), (n > 0) ? 32'(m_stk[n-1]) : 32'd0);
    check({tag, "_nos"}, 32'(o_nos), (n > 1) ? 32'(m_stk[n-2]) : 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    m_stk.delete();
  endtask

  // Issue one command in IDLE and follow it to completion; ALU ops also get a
  // held junk PUSH during the busy cycles, which must be ignored.
  task automatic do_cmd(input logic [1:0] c, input logic [3:0] op, input logic [7:0] d);
    int n = m_stk.size();
    bit legal = 1'b0;
    bit bin = (op <= 4'd5);
    logic [7:0] a0, a1, res;
    @(negedge i_clk);
    check("ready_pre", 32'(o_ready), 32'd1);
    check("err_idle", 32'(o_err), 32'd0);
    i_valid = 1'b1; i_cmd = c; i_op = op; i_data = d;
    case (c)
      2'd0: begin legal = (n < DEPTH); if (legal) m_stk.push_back(d); end
      2'd1: begin legal = (n > 0); if (legal) void'(m_stk.pop_back()); end
      2'd2: begin legal = (n > 0) && (n < DEPTH); if (legal) m_stk.push_back(m_stk[n-1]); end
      default: legal = bin ? (n >= 2) : (n >= 1);
    endcase
    @(negedge i_clk);
    if (c == 2'd3 && legal) begin
      a1 = bin ? m_stk[n-1] : 8'd0;
      a0 = bin ? m_stk[n-2] : m_stk[n-1];
      check("alu_op", 32'(o_alu_op), 32'(op));
      check("alu_arg0", 32'(o_alu_arg0), 32'(a0));
      check("alu_arg1", 32'(o_alu_arg1), 32'(a1));
      check("issue_ready", 32'(o_ready), 32'd0);
      check("issue_tos", 32'(o_tos), 32'(m_stk[n-1]));
      i_cmd = 2'd0; i_data = 8'($urandom);
      @(negedge i_clk);
      check("wait_ready", 32'(o_ready), 32'd0);
      check("wait_depth", 32'(o_depth), 32'(n));
      i_valid = 1'b0;
      res = alu_f(op, a0, a1);
      if (bin) begin
        void'(m_stk.pop_back());
        void'(m_stk.pop_back());
        m_stk.push_back(res);
      end else begin
        m_stk[n-1] = res;
      end
      @(negedge i_clk);
      check("alu_err", 32'(o_err), 32'd0);
    end else begin
      i_valid = 1'b0;
      check("cmd_err", 32'(o_err), legal ? 32'd0 : 32'd1);
    end
    check_state("post");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_dut();
    @(negedge i_clk);
    check_state("reset");
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_op", 32'(o_alu_op), 32'd0);
    check("reset_arg0", 32'(o_alu_arg0), 32'd0);
    check("reset_arg1", 32'(o_alu_arg1), 32'd0);

    do_cmd(0, 0, 8'd5); do_cmd(0, 0, 8'd3); do_cmd(3, 4'd0, 0);
    check("add_tos", 32'(o_tos), 32'd8);
    check("add_depth", 32'(o_depth), 32'd1);
    do_cmd(1, 0, 0);
    do_cmd(0, 0, 8'd5); do_cmd(0, 0, 8'd3); do_cmd(3, 4'd1, 0);
    check("sub_tos", 32'(o_tos), 32'd2);
    do_cmd(1, 0, 0);
    do_cmd(0, 0, 8'd3); do_cmd(0, 0, 8'd5); do_cmd(3, 4'd1, 0);
    check("sub_wrap", 32'(o_tos), 32'hFE);
    do_cmd(1, 0, 0);
    do_cmd(0, 0, 8'h81); do_cmd(3, 4'd6, 0);
    check("rol_tos", 32'(o_tos), 32'h03);
    check("rol_depth", 32'(o_depth), 32'd1);
    do_cmd(1, 0, 0);
    do_cmd(0, 0, 8'h10); do_cmd(0, 0, 8'h10); do_cmd(3, 4'd2, 0);
    check("mul_tos", 32'(o_tos), 32'h00);
    do_cmd(1, 0, 0);
    do_cmd(1, 0, 0);
    check("pop_empty_depth", 32'(o_depth), 32'd0);
    for (int i = 0; i <= DEPTH; i++) do_cmd(0, 0, 8'(i + 1));
    check("full_depth", 32'(o_depth), 32'(DEPTH));
    do_cmd(2, 0, 0);

    reset_dut();
    do_cmd(0, 0, 8'd7); do_cmd(3, 4'd3, 0);
    check("and_short_tos", 32'(o_tos), 32'd7);
    do_cmd(2, 0, 0);
    check("dup_nos", 32'(o_nos), 32'd7);
    check("dup_depth", 32'(o_depth), 32'd2);

    reset_dut();
    do_cmd(0, 0, 8'd1); do_cmd(0, 0, 8'd2);
    @(negedge i_clk);
    i_valid = 1'b1; i_cmd = 2'd3; i_op = 4'd4;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_wait_depth", 32'(o_depth), 32'd0);
    check("rst_wait_op", 32'(o_alu_op), 32'd0);
    check("rst_wait_arg0", 32'(o_alu_arg0), 32'd0);
    check("rst_wait_arg1", 32'(o_alu_arg1), 32'd0);
    check("rst_ready_low", 32'(o_ready), 32'd0);
    i_rst = 1'b0;
    m_stk.delete();
    #1;
    check("rst_ready_high", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    check("rst_wait_depth2", 32'(o_depth), 32'd0);
    do_cmd(0, 0, 8'd9);

    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] c = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      do_cmd(c, 4'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
